// File: rtl/car_controller.sv
// car_controller
//   Moore FSM steering a car across lanes 0..POS_MAX. A held direction
//   button steps the car once every STEP_CYCLES cycles, with the first
//   step taken at the end of the first cycle in LEFT/RIGHT. Each
//   collision costs one life. While lives remain, the car shows a
//   collision, then blanks for RESPAWN_CYCLES cycles, then respawns at
//   POS_INIT. When the last life is lost, the block sits in GAME_OVER
//   until reset.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   btnL, btnR   steer left (decrement) / right (increment)
//   collision    collision level from the track logic
//   car_move     00 idle/respawn, 01 left, 10 right, 11 collide/game over
//   car_pos      current lane position
//   lives_left   remaining lives
//   game_over    high in GAME_OVER
//   o_dbg_state  current FSM state encoding (debug)
module car_controller #(
    parameter int POS_W          = 4,
    parameter int POS_MAX        = 11,
    parameter int POS_INIT       = 5,
    parameter int STEP_CYCLES    = 4,
    parameter int RESPAWN_CYCLES = 8,
    parameter int LIVES          = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btnL,
    input  logic             btnR,
    input  logic             collision,
    output logic [1:0]       car_move,
    output logic [POS_W-1:0] car_pos,
    output logic [1:0]       lives_left,
    output logic             game_over,
    output logic [2:0]       o_dbg_state
);

    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int RESP_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_IDLE      = 3'd1,
        S_LEFT      = 3'd2,
        S_RIGHT     = 3'd3,
        S_COLLIDE   = 3'd4,
        S_RESPAWN   = 3'd5,
        S_GAME_OVER = 3'd6
    } state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic [1:0]         r_lives;
    logic [STEP_W-1:0]  r_step;
    logic [RESP_W-1:0]  r_resp;

    state_t             w_state_nx;
    logic [POS_W-1:0]   w_pos_nx;
    logic [1:0]         w_lives_nx;
    logic [STEP_W-1:0]  w_step_nx;
    logic [RESP_W-1:0]  w_resp_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_START;
            r_pos   <= POS_W'(POS_INIT);
            r_lives <= 2'(LIVES);
            r_step  <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_lives <= w_lives_nx;
            r_step  <= w_step_nx;
            r_resp  <= w_resp_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_pos_nx   = r_pos;
        w_lives_nx = r_lives;
        w_step_nx  = '0;
        w_resp_nx  = '0;
        case (r_state)
            S_START: w_state_nx = S_IDLE;

            S_IDLE, S_LEFT, S_RIGHT: begin
                if (collision) begin
                    // Collision wins over steering: no position step on this edge.
                    w_lives_nx = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
                    w_state_nx = (r_lives > 2'd1) ? S_COLLIDE : S_GAME_OVER;
                end else begin
                    // A step is taken whenever the step counter is at zero,
                    // even on the cycle the button is released.
                    if (r_state == S_LEFT && r_step == '0 && r_pos != '0)
                        w_pos_nx = r_pos - POS_W'(1);
                    if (r_state == S_RIGHT && r_step == '0 && r_pos != POS_W'(POS_MAX))
                        w_pos_nx = r_pos + POS_W'(1);

                    if (btnL && !btnR)
                        w_state_nx = S_LEFT;
                    else if (btnR && !btnL)
                        w_state_nx = S_RIGHT;
                    else
                        w_state_nx = S_IDLE;

                    // Counter only runs while staying in the same direction;
                    // entering or switching direction restarts it at zero.
                    if (w_state_nx == r_state && r_state != S_IDLE)
                        w_step_nx = (r_step == STEP_W'(STEP_CYCLES - 1)) ? '0 : r_step + STEP_W'(1);
                end
            end

            S_COLLIDE: begin
                if (!collision)
                    w_state_nx = S_RESPAWN;
            end

            S_RESPAWN: begin
                if (r_resp == RESP_W'(RESPAWN_CYCLES - 1)) begin
                    w_state_nx = S_START;
                    w_pos_nx   = POS_W'(POS_INIT);
                end else begin
                    w_resp_nx = r_resp + RESP_W'(1);
                end
            end

            S_GAME_OVER: w_state_nx = S_GAME_OVER;

            default: w_state_nx = S_START;
        endcase
    end

    always_comb begin
        car_move = 2'b00;
        case (r_state)
            S_LEFT:                 car_move = 2'b01;
            S_RIGHT:                car_move = 2'b10;
            S_COLLIDE, S_GAME_OVER: car_move = 2'b11;
            default:                car_move = 2'b00;
        endcase
    end

    assign game_over   = (r_state == S_GAME_OVER);
    assign car_pos     = r_pos;
    assign lives_left  = r_lives;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_car_controller.sv
module tb_car_controller;

  localparam logic [2:0] ST_START     = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_LEFT      = 3'd2;
  localparam logic [2:0] ST_RIGHT     = 3'd3;
  localparam logic [2:0] ST_COLLIDE   = 3'd4;
  localparam logic [2:0] ST_RESPAWN   = 3'd5;
  localparam logic [2:0] ST_GAME_OVER = 3'd6;

  logic       clk;
  logic       rst_n;
  logic       btnL;
  logic       btnR;
  logic       collision;
  logic [1:0] car_move;
  logic [3:0] car_pos;
  logic [1:0] lives_left;
  logic       game_over;
  logic [2:0] dbg_state;

  int tests_run;
  int tests_failed;

  car_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btnL        (btnL),
    .btnR        (btnR),
    .collision   (collision),
    .car_move    (car_move),
    .car_pos     (car_pos),
    .lives_left  (lives_left),
    .game_over   (game_over),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [1:0] mv,
                           input logic [3:0] pos, input logic [1:0] lv, input logic go);
    check({tag, ".state"}, 32'(dbg_state), 32'(st));
    check({tag, ".move"},  32'(car_move),  32'(mv));
    check({tag, ".pos"},   32'(car_pos),   32'(pos));
    check({tag, ".lives"}, 32'(lives_left), 32'(lv));
    check({tag, ".go"},    32'(game_over), 32'(go));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    btnL      = 1'b0;
    btnR      = 1'b0;
    collision = 1'b0;

    // reset for 2 cycles
    step(2);
    check_all("reset", ST_START, 2'b00, 4'd5, 2'd3, 1'b0);

    // collision ignored in START; START lasts one cycle
    rst_n = 1'b1;
    collision = 1'b1;
    step(1);
    check_all("start_to_idle", ST_IDLE, 2'b00, 4'd5, 2'd3, 1'b0);
    collision = 1'b0;

    // hold btnL: first step one cycle after entry, then every 4 cycles
    btnL = 1'b1;
    step(1);
    check_all("left_entry", ST_LEFT, 2'b01, 4'd5, 2'd3, 1'b0);
    step(1);
    check("left_pos4", 32'(car_pos), 32'd4);
    step(3);
    check("left_hold4", 32'(car_pos), 32'd4);
    step(1);
    check("left_pos3", 32'(car_pos), 32'd3);
    step(4);
    check("left_pos2", 32'(car_pos), 32'd2);
    step(8);
    check("left_pos0", 32'(car_pos), 32'd0);
    step(8);
    check_all("left_sat0", ST_LEFT, 2'b01, 4'd0, 2'd3, 1'b0);

    // switch directly to RIGHT, saturate at 11
    btnL = 1'b0;
    btnR = 1'b1;
    step(1);
    check_all("right_entry", ST_RIGHT, 2'b10, 4'd0, 2'd3, 1'b0);
    step(1);
    check("right_pos1", 32'(car_pos), 32'd1);
    step(40);
    check("right_pos11", 32'(car_pos), 32'd11);
    step(8);
    check_all("right_sat11", ST_RIGHT, 2'b10, 4'd11, 2'd3, 1'b0);

    // release to IDLE, then both buttons for 5 cycles
    btnR = 1'b0;
    step(1);
    check_all("release_idle", ST_IDLE, 2'b00, 4'd11, 2'd3, 1'b0);
    btnL = 1'b1;
    btnR = 1'b1;
    step(5);
    check_all("both_idle", ST_IDLE, 2'b00, 4'd11, 2'd3, 1'b0);

    // one left step to 10, then into RIGHT at step_cnt 0
    btnR = 1'b0;
    step(2);
    check("pre_coll_pos10", 32'(car_pos), 32'd10);
    btnL = 1'b0;
    btnR = 1'b1;
    step(1);
    check_all("pre_coll_right", ST_RIGHT, 2'b10, 4'd10, 2'd3, 1'b0);

    // collision 3 cycles in RIGHT: no step on the collision edge
    collision = 1'b1;
    step(1);
    check_all("coll1", ST_COLLIDE, 2'b11, 4'd10, 2'd2, 1'b0);
    step(2);
    check_all("coll_hold", ST_COLLIDE, 2'b11, 4'd10, 2'd2, 1'b0);
    collision = 1'b0;
    step(1);
    check_all("respawn_entry", ST_RESPAWN, 2'b00, 4'd10, 2'd2, 1'b0);

    // respawn ignores buttons and collision for 8 cycles
    btnR = 1'b0;
    btnL = 1'b1;
    collision = 1'b1;
    step(7);
    check_all("respawn_last", ST_RESPAWN, 2'b00, 4'd10, 2'd2, 1'b0);
    step(1);
    check_all("respawn_done", ST_START, 2'b00, 4'd5, 2'd2, 1'b0);
    step(1);
    check_all("respawn_idle", ST_IDLE, 2'b00, 4'd5, 2'd2, 1'b0);

    // second collision from IDLE (collision still high)
    step(1);
    check_all("coll2", ST_COLLIDE, 2'b11, 4'd5, 2'd1, 1'b0);
    collision = 1'b0;
    btnL = 1'b0;
    step(9);
    check_all("coll2_start", ST_START, 2'b00, 4'd5, 2'd1, 1'b0);
    step(1);
    check("coll2_idle", 32'(dbg_state), 32'(ST_IDLE));

    // third collision -> GAME_OVER, held against all inputs
    collision = 1'b1;
    step(1);
    check_all("game_over", ST_GAME_OVER, 2'b11, 4'd5, 2'd0, 1'b1);
    collision = 1'b0;
    btnR = 1'b1;
    step(5);
    collision = 1'b1;
    btnL = 1'b1;
    step(5);
    check_all("game_over_hold", ST_GAME_OVER, 2'b11, 4'd5, 2'd0, 1'b1);

    // reset out of GAME_OVER
    btnL = 1'b0;
    btnR = 1'b0;
    collision = 1'b0;
    rst_n = 1'b0;
    step(1);
    check_all("go_reset", ST_START, 2'b00, 4'd5, 2'd3, 1'b0);
    rst_n = 1'b1;
    step(1);

    // move to 6, collide, then reset mid-RESPAWN
    btnR = 1'b1;
    step(2);
    check("mid_pos6", 32'(car_pos), 32'd6);
    collision = 1'b1;
    step(1);
    check_all("mid_coll", ST_COLLIDE, 2'b11, 4'd6, 2'd2, 1'b0);
    collision = 1'b0;
    step(4);
    check_all("mid_respawn", ST_RESPAWN, 2'b00, 4'd6, 2'd2, 1'b0);
    rst_n = 1'b0;
    step(1);
    check_all("mid_reset", ST_START, 2'b00, 4'd5, 2'd3, 1'b0);

    // after reset, respawn counter starts fresh: full 8-cycle blanking
    rst_n = 1'b1;
    btnR = 1'b0;
    step(1);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    step(1);
    check("fresh_respawn", 32'(dbg_state), 32'(ST_RESPAWN));
    step(7);
    check("fresh_respawn_7", 32'(dbg_state), 32'(ST_RESPAWN));
    step(1);
    check_all("fresh_respawn_end", ST_START, 2'b00, 4'd5, 2'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/car_controller.md
CAR_CONTROLLER -- requirements
Module: car_controller

Interface
REQ-001 SHALL have parameter POS_W, default 4: width of car_pos.
REQ-002 SHALL have parameter POS_MAX, default 11: rightmost lane position. Constraint: POS_MAX < 2^POS_W.
REQ-003 SHALL have parameter POS_INIT, default 5: spawn position. Constraint: POS_INIT <= POS_MAX.
REQ-004 SHALL have parameter STEP_CYCLES, default 4: cycles per lane step while a direction is held. Constraint: >= 1.
REQ-005 SHALL have parameter RESPAWN_CYCLES, default 8: blanking cycles after a collision clears. Constraint: >= 1.
REQ-006 SHALL have parameter LIVES, default 3: collisions allowed before game over, 1..3.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port btnL, input, 1 bit: steer left (decreasing position).
REQ-010 SHALL have port btnR, input, 1 bit: steer right (increasing position).
REQ-011 SHALL have port collision, input, 1 bit: collision level from the track logic.
REQ-012 SHALL have port car_move, output, 2 bits: 00 idle, 01 left, 10 right, 11 collide or game over.
REQ-013 SHALL have port car_pos, output, POS_W bits: current lane position.
REQ-014 SHALL have port lives_left, output, 2 bits: remaining lives.
REQ-015 SHALL have port game_over, output, 1 bit: high in GAME_OVER.

Function
REQ-016 SHALL implement a Moore FSM with states START, IDLE, LEFT, RIGHT, COLLIDE, RESPAWN and GAME_OVER. All outputs SHALL be decoded from registers only.
REQ-017 SHALL move from START to IDLE after exactly 1 cycle. car_move SHALL be 00 and collision SHALL be ignored in START.
REQ-018 IDLE, LEFT and RIGHT SHALL share one next-state priority:
  - collision
  - then btnL && !btnR goes to LEFT
  - then btnR && !btnL goes to RIGHT
  - otherwise go to IDLE; both or neither button pressed means IDLE.
REQ-019 car_move SHALL be 00 in IDLE and RESPAWN, 01 in LEFT, 10 in RIGHT, and 11 in COLLIDE and GAME_OVER.
REQ-020 step_cnt SHALL work as follows:
  - counts 0..STEP_CYCLES-1 and wraps while the state is LEFT or RIGHT;
  - is forced to 0 in every other state;
  - is forced to 0 on a LEFT<->RIGHT switch.
REQ-021 In LEFT, on every cycle with step_cnt==0, car_pos SHALL decrement at that cycle's closing edge, saturating at 0. The first step is therefore visible 1 cycle after entering LEFT.
REQ-022 In RIGHT, the same rule SHALL apply with car_pos incrementing, saturating at POS_MAX.
REQ-023 A collision seen in IDLE, LEFT or RIGHT SHALL decrement lives_left by 1 on that edge, with no position step on that edge.
REQ-024 After that decrement, the next state SHALL be COLLIDE if the old lives_left was > 1, otherwise GAME_OVER.
REQ-025 COLLIDE SHALL hold while collision=1 and go to RESPAWN on the first cycle with collision=0. lives_left SHALL NOT decrement again while in COLLIDE.
REQ-026 RESPAWN SHALL last exactly RESPAWN_CYCLES cycles and ignore btnL, btnR and collision.
REQ-027 On the final RESPAWN edge, car_pos SHALL load POS_INIT and the state SHALL go to START.
REQ-028 GAME_OVER SHALL hold car_move=11 and game_over=1, and ignore all inputs until rst_n=0.
REQ-029 Unused state encodings SHALL go to START on the next edge.

Reset
REQ-030 On any edge with rst_n=0, in any state including mid-step or mid-RESPAWN, the block SHALL load: state START, car_pos POS_INIT, lives_left LIVES, step_cnt 0, respawn counter 0.
REQ-031 During reset, car_move SHALL be 00 and game_over SHALL be 0.
REQ-032 No output SHALL change asynchronously to clk.

Verification (defaults)
REQ-033 Reset for 2 cycles -> car_pos=5, lives_left=3, car_move=00, game_over=0; START for 1 cycle after release, then IDLE.
REQ-034 From IDLE, hold btnL for 10 cycles -> car_move=01; car_pos 5->4 one cycle after LEFT entry, then 3 and 2 at 4-cycle spacing.
REQ-035 With car_pos=0, hold btnL; then with car_pos=11, hold btnR -> car_pos stays 0 and 11 respectively, with car_move 01 and 10.
REQ-036 In IDLE, press btnL and btnR together for 5 cycles -> state stays IDLE, car_move=00, car_pos unchanged.
REQ-037 Collision high for 3 cycles in RIGHT -> lives_left=2, car_move=11 for 3 cycles, then 8 cycles of RESPAWN ignoring buttons, then car_pos=5, START, IDLE.
REQ-038 Third collision -> GAME_OVER with game_over=1, held against all inputs. Separately, assert rst_n=0 mid-RESPAWN -> reset values on the next edge.
